// File: rtl/master_bridge_r_channel_sync_buffer.sv
// Read-channel sync buffer: separate data and descriptor FIFOs merged into a
// first-word-fall-through read stream with per-burst last generation.
module master_bridge_r_channel_sync_buffer #(
    parameter int unsigned BEAT_SIZE       = 1024,
    parameter int unsigned R_CH_INFO_WIDTH = 56,
    parameter int unsigned DATA_ADDR_WIDTH = 5,
    parameter int unsigned INFO_ADDR_WIDTH = 3,
    parameter int unsigned LEN_WIDTH       = 8,
    parameter int unsigned AFULL_THRESH    = 28
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_w_info_inc,
    input  logic [R_CH_INFO_WIDTH-1:0] i_w_info,
    input  logic [LEN_WIDTH-1:0]       i_w_len,
    input  logic                       i_w_data_inc,
    input  logic [BEAT_SIZE-1:0]       i_w_data,
    input  logic                       i_r_ready,
    output logic                       o_r_valid,
    output logic [BEAT_SIZE-1:0]       o_r_data,
    output logic [R_CH_INFO_WIDTH-1:0] o_r_info,
    output logic                       o_r_last,
    output logic                       o_w_info_full,
    output logic                       o_w_data_full,
    output logic                       o_w_data_afull,
    output logic [DATA_ADDR_WIDTH:0]   o_data_count,
    output logic                       o_ovf_err
);

    localparam int unsigned DataDepth = 1 << DATA_ADDR_WIDTH;
    localparam int unsigned InfoDepth = 1 << INFO_ADDR_WIDTH;
    localparam int unsigned InfoEntry = LEN_WIDTH + R_CH_INFO_WIDTH;
    localparam logic [DATA_ADDR_WIDTH:0] AfullCnt = (DATA_ADDR_WIDTH + 1)'(AFULL_THRESH);

    logic [BEAT_SIZE-1:0] data_mem [DataDepth];
    logic [InfoEntry-1:0] info_mem [InfoDepth];

    logic [DATA_ADDR_WIDTH:0] data_wptr_q, data_wptr_d, data_rptr_q, data_rptr_d;
    logic [INFO_ADDR_WIDTH:0] info_wptr_q, info_wptr_d, info_rptr_q, info_rptr_d;
    logic [LEN_WIDTH-1:0]     beat_cnt_q, beat_cnt_d;
    logic                     ovf_q, ovf_d;

    logic                 data_empty, data_full, info_empty, info_full;
    logic                 r_valid, r_last, handshake;
    logic                 data_push, data_pop, info_push, info_pop;
    logic [InfoEntry-1:0] info_head;
    logic [LEN_WIDTH-1:0] head_len;

    assign data_empty = (data_wptr_q == data_rptr_q);
    assign data_full  = (data_wptr_q[DATA_ADDR_WIDTH] != data_rptr_q[DATA_ADDR_WIDTH]) &&
                        (data_wptr_q[DATA_ADDR_WIDTH-1:0] == data_rptr_q[DATA_ADDR_WIDTH-1:0]);
    assign info_empty = (info_wptr_q == info_rptr_q);
    assign info_full  = (info_wptr_q[INFO_ADDR_WIDTH] != info_rptr_q[INFO_ADDR_WIDTH]) &&
                        (info_wptr_q[INFO_ADDR_WIDTH-1:0] == info_rptr_q[INFO_ADDR_WIDTH-1:0]);

    assign info_head = info_mem[info_rptr_q[INFO_ADDR_WIDTH-1:0]];
    assign head_len  = info_head[InfoEntry-1 -: LEN_WIDTH];

    assign r_valid   = !info_empty && !data_empty;
    assign r_last    = r_valid && (beat_cnt_q == head_len);
    assign handshake = r_valid && i_r_ready;
    assign data_pop  = handshake;
    assign info_pop  = handshake && r_last;

    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign data_push = i_w_data_inc && (!data_full || data_pop);
    assign info_push = i_w_info_inc && (!info_full || info_pop);

    always_comb begin
        data_wptr_d = data_wptr_q;
        data_rptr_d = data_rptr_q;
        info_wptr_d = info_wptr_q;
        info_rptr_d = info_rptr_q;
        beat_cnt_d  = beat_cnt_q;
        ovf_d       = ovf_q;
        if (data_push) data_wptr_d = data_wptr_q + 1'b1;
        if (data_pop)  data_rptr_d = data_rptr_q + 1'b1;
        if (info_push) info_wptr_d = info_wptr_q + 1'b1;
        if (info_pop)  info_rptr_d = info_rptr_q + 1'b1;
        if (handshake) begin
            beat_cnt_d = r_last ? '0 : beat_cnt_q + 1'b1;
        end
        if ((i_w_data_inc && !data_push) || (i_w_info_inc && !info_push)) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_wptr_q <= '0;
            data_rptr_q <= '0;
            info_wptr_q <= '0;
            info_rptr_q <= '0;
            beat_cnt_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            data_wptr_q <= data_wptr_d;
            data_rptr_q <= data_rptr_d;
            info_wptr_q <= info_wptr_d;
            info_rptr_q <= info_rptr_d;
            beat_cnt_q  <= beat_cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    // Storage arrays carry no reset; the pointers alone define what is valid.
    always_ff @(posedge i_clk) begin
        if (data_push) data_mem[data_wptr_q[DATA_ADDR_WIDTH-1:0]] <= i_w_data;
        if (info_push) info_mem[info_wptr_q[INFO_ADDR_WIDTH-1:0]] <= {i_w_len, i_w_info};
    end

    assign o_r_valid      = r_valid;
    assign o_r_last       = r_last;
    assign o_r_data       = r_valid ? data_mem[data_rptr_q[DATA_ADDR_WIDTH-1:0]] : '0;
    assign o_r_info       = r_valid ? info_head[R_CH_INFO_WIDTH-1:0] : '0;
    assign o_w_info_full  = info_full;
    assign o_w_data_full  = data_full;
    assign o_data_count   = data_wptr_q - data_rptr_q;
    assign o_w_data_afull = (o_data_count >= AfullCnt);
    assign o_ovf_err      = ovf_q;

endmodule
